// File: rtl/pvr_interp_pkg.sv
// Shared types and defaults for the plane-equation interpolation blocks
// (setup/evaluate and the span walker).
package pvr_interp_pkg;

    localparam int unsigned DEF_COEF_W = 64;
    localparam int unsigned DEF_OUT_W  = 32;
    localparam int unsigned DEF_TILE_W = 32;
    localparam int unsigned DEF_TILE_H = 32;

    // 12-bit signed screen coordinate, shared with the setup/evaluate block
    typedef logic signed [11:0] scr_coord_t;

    // Walker sequencing: wait for start, one-cycle start-value setup, pixel span
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_SPAN = 2'd2
    } walker_state_t;

    // Sign-extend a screen coordinate into a 64-bit accumulator lane
    function automatic logic signed [63:0] coord_sext64(input scr_coord_t c);
        coord_sext64 = {{52{c[11]}}, c};
    endfunction

endpackage

// File: rtl/plane_start_calc.sv
// Start value of the plane equation at the tile origin:
//   start = tile_x*ddx + tile_y*ddy + c   (modulo 2^COEF_W)
// Kept combinational and separate so it can be pipelined without
// disturbing the walker FSM.
module plane_start_calc
    import pvr_interp_pkg::*;
#(
    parameter int COEF_W = DEF_COEF_W
) (
    input  logic signed [COEF_W-1:0] i_ddx,
    input  logic signed [COEF_W-1:0] i_ddy,
    input  logic signed [COEF_W-1:0] i_c,
    input  scr_coord_t               i_tx,
    input  scr_coord_t               i_ty,
    output logic signed [COEF_W-1:0] o_start
);

    logic signed [COEF_W-1:0] w_tx_ext;
    logic signed [COEF_W-1:0] w_ty_ext;
    logic signed [COEF_W-1:0] w_px;
    logic signed [COEF_W-1:0] w_py;

    // Coordinates are sign-extended so negative tile origins multiply correctly
    assign w_tx_ext = {{(COEF_W-12){i_tx[11]}}, i_tx};
    assign w_ty_ext = {{(COEF_W-12){i_ty[11]}}, i_ty};

    // Products truncate to COEF_W bits, giving modulo-2^COEF_W arithmetic
    assign w_px    = w_tx_ext * i_ddx;
    assign w_py    = w_ty_ext * i_ddy;
    assign o_start = w_px + w_py + i_c;

endmodule

// File: rtl/plane_span_walker.sv
// Walks every pixel of a tile in raster order and emits the plane value
// x*ddx + y*ddy + c per pixel on a valid/ready stream. One start-value
// multiply in INIT, then only incremental adds per pixel.
module plane_span_walker
    import pvr_interp_pkg::*;
#(
    parameter int TILE_W = DEF_TILE_W,
    parameter int TILE_H = DEF_TILE_H,
    parameter int COEF_W = DEF_COEF_W,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic signed [COEF_W-1:0] coef_ddx,
    input  logic signed [COEF_W-1:0] coef_ddy,
    input  logic signed [COEF_W-1:0] coef_c,
    input  logic signed [11:0]       tile_x,
    input  logic signed [11:0]       tile_y,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [11:0]       out_x,
    output logic signed [11:0]       out_y,
    output logic [OUT_W-1:0]         out_value,
    output logic                     out_last
);

    localparam int CW = $clog2(TILE_W);
    localparam int RW = $clog2(TILE_H);
    localparam logic [CW-1:0] COL_MAX = CW'(TILE_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(TILE_H - 1);

    walker_state_t            r_state;
    logic signed [COEF_W-1:0] r_ddx;
    logic signed [COEF_W-1:0] r_ddy;
    logic signed [COEF_W-1:0] r_c;
    scr_coord_t               r_tx;
    scr_coord_t               r_ty;
    logic signed [COEF_W-1:0] r_row_acc;
    logic signed [COEF_W-1:0] r_pix_acc;
    logic [CW-1:0]            r_col;
    logic [RW-1:0]            r_row;
    logic                     r_busy;
    logic                     r_out_valid;
    logic                     r_out_last;
    scr_coord_t               r_out_x;
    scr_coord_t               r_out_y;
    logic [OUT_W-1:0]         r_out_value;

    logic signed [COEF_W-1:0] w_start_val;
    logic signed [COEF_W-1:0] w_pix_next;
    logic signed [COEF_W-1:0] w_row_next;
    logic [CW-1:0]            w_col_inc;
    logic [RW-1:0]            w_row_inc;
    logic                     w_fire;
    logic                     w_col_end;
    logic                     w_at_last;
    logic                     w_last_next;
    scr_coord_t               w_x_next;
    scr_coord_t               w_y_next;

    plane_start_calc #(
        .COEF_W (COEF_W)
    ) u_start_calc (
        .i_ddx   (r_ddx),
        .i_ddy   (r_ddy),
        .i_c     (r_c),
        .i_tx    (r_tx),
        .i_ty    (r_ty),
        .o_start (w_start_val)
    );

    // Incremental stepping: next pixel along the row, or start of next row
    assign w_pix_next  = r_pix_acc + r_ddx;
    assign w_row_next  = r_row_acc + r_ddy;
    assign w_col_inc   = r_col + {{(CW-1){1'b0}}, 1'b1};
    assign w_row_inc   = r_row + {{(RW-1){1'b0}}, 1'b1};
    assign w_fire      = r_out_valid & out_ready;
    assign w_col_end   = (r_col == COL_MAX);
    assign w_at_last   = w_col_end & (r_row == ROW_MAX);
    assign w_last_next = (w_col_inc == COL_MAX) & (r_row == ROW_MAX);
    assign w_x_next    = r_tx + 12'(w_col_inc);
    assign w_y_next    = r_ty + 12'(w_row_inc);

    // Walker FSM: all stream outputs are registered and only move on a handshake
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_ddx       <= '0;
            r_ddy       <= '0;
            r_c         <= '0;
            r_tx        <= 12'sd0;
            r_ty        <= 12'sd0;
            r_row_acc   <= '0;
            r_pix_acc   <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_x     <= 12'sd0;
            r_out_y     <= 12'sd0;
            r_out_value <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ddx   <= coef_ddx;
                        r_ddy   <= coef_ddy;
                        r_c     <= coef_c;
                        r_tx    <= tile_x;
                        r_ty    <= tile_y;
                        r_busy  <= 1'b1;
                        r_state <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    r_row_acc   <= w_start_val;
                    r_pix_acc   <= w_start_val;
                    r_col       <= '0;
                    r_row       <= '0;
                    r_out_valid <= 1'b1;
                    r_out_value <= w_start_val[OUT_W-1:0];
                    r_out_x     <= r_tx;
                    r_out_y     <= r_ty;
                    r_out_last  <= 1'b0;
                    r_state     <= ST_SPAN;
                end
                ST_SPAN: begin
                    if (w_fire) begin
                        if (w_at_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else if (!w_col_end) begin
                            r_col       <= w_col_inc;
                            r_pix_acc   <= w_pix_next;
                            r_out_value <= w_pix_next[OUT_W-1:0];
                            r_out_x     <= w_x_next;
                            r_out_last  <= w_last_next;
                        end else begin
                            r_col       <= '0;
                            r_row       <= w_row_inc;
                            r_row_acc   <= w_row_next;
                            r_pix_acc   <= w_row_next;
                            r_out_value <= w_row_next[OUT_W-1:0];
                            r_out_x     <= r_tx;
                            r_out_y     <= w_y_next;
                            r_out_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_value = r_out_value;

endmodule

// File: tb/tb_plane_span_walker.sv
// Directed bench for plane_span_walker: each beat is compared with the
// plane equation evaluated directly from the pixel coordinate.
module tb_plane_span_walker;

    localparam int NBEATS = 1024;
    localparam int BUDGET = 20000;

    logic               clock;
    logic               reset_n;
    logic               start;
    logic signed [63:0] coef_ddx;
    logic signed [63:0] coef_ddy;
    logic signed [63:0] coef_c;
    logic signed [11:0] tile_x;
    logic signed [11:0] tile_y;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic signed [11:0] out_x;
    logic signed [11:0] out_y;
    logic [31:0]        out_value;
    logic               out_last;

    int total = 0;
    int bad   = 0;

    plane_span_walker dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .coef_ddx  (coef_ddx),
        .coef_ddy  (coef_ddy),
        .coef_c    (coef_c),
        .tile_x    (tile_x),
        .tile_y    (tile_y),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_value (out_value),
        .out_last  (out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Run one tile walk; optional second start at beat restart_at and
    // one-cycle reset at beat reset_at (-1 disables each).
    task automatic walk(input longint ddx, input longint ddy, input longint c,
                        input int tx, input int ty, input bit rnd,
                        input int restart_at, input int reset_at,
                        input int sb0, input longint sv0,
                        input int sb1, input longint sv1);
        int     b;
        int     cyc;
        bit     rdy;
        longint x;
        longint y;
        longint ev;
        logic [11:0] ex;
        logic [11:0] ey;
        logic [31:0] sv;
        coef_ddx = ddx;
        coef_ddy = ddy;
        coef_c   = c;
        tile_x   = 12'(tx);
        tile_y   = 12'(ty);
        start    = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("busy_init", {63'd0, busy}, 64'd1);
        chk("valid_init", {63'd0, out_valid}, 64'd0);
        @(posedge clock); #1;
        b   = 0;
        cyc = 0;
        while (b < NBEATS && cyc < BUDGET) begin
            x  = longint'(tx + (b % 32));
            y  = longint'(ty + (b / 32));
            ev = x * ddx + y * ddy + c;
            ex = 12'(x);
            ey = 12'(y);
            chk("valid", {63'd0, out_valid}, 64'd1);
            chk("busy", {63'd0, busy}, 64'd1);
            chk("x", {52'd0, out_x}, {52'd0, ex});
            chk("y", {52'd0, out_y}, {52'd0, ey});
            chk("value", {32'd0, out_value}, {32'd0, ev[31:0]});
            chk("last", {63'd0, out_last}, (b == NBEATS - 1) ? 64'd1 : 64'd0);
            if (b == sb0) begin
                sv = sv0[31:0];
                chk("spot0", {32'd0, out_value}, {32'd0, sv});
            end
            if (b == sb1) begin
                sv = sv1[31:0];
                chk("spot1", {32'd0, out_value}, {32'd0, sv});
            end
            rdy = rnd ? ($urandom_range(0, 99) < 40) : 1'b1;
            out_ready = rdy;
            if (b == restart_at) begin
                coef_ddx = 64'sd77;
                coef_ddy = -64'sd13;
                coef_c   = 64'sd5000;
                tile_x   = 12'sd100;
                tile_y   = 12'sd100;
                start    = 1'b1;
            end
            if (b == reset_at) reset_n = 1'b0;
            @(posedge clock); #1;
            start = 1'b0;
            if (b == reset_at) begin
                reset_n   = 1'b1;
                out_ready = 1'b0;
                chk("rst_valid", {63'd0, out_valid}, 64'd0);
                chk("rst_busy", {63'd0, busy}, 64'd0);
                chk("rst_last", {63'd0, out_last}, 64'd0);
                chk("rst_x", {52'd0, out_x}, 64'd0);
                chk("rst_y", {52'd0, out_y}, 64'd0);
                chk("rst_value", {32'd0, out_value}, 64'd0);
                @(posedge clock); #1;
                chk("rst_idle_valid", {63'd0, out_valid}, 64'd0);
                return;
            end
            if (rdy) b++;
            cyc++;
        end
        if (cyc >= BUDGET) chk("timeout", 64'd0, 64'd1);
        out_ready = 1'b0;
        chk("busy_end", {63'd0, busy}, 64'd0);
        chk("valid_end", {63'd0, out_valid}, 64'd0);
        chk("last_end", {63'd0, out_last}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        coef_ddx  = 64'sd0;
        coef_ddy  = 64'sd0;
        coef_c    = 64'sd0;
        tile_x    = 12'sd0;
        tile_y    = 12'sd0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_last", {63'd0, out_last}, 64'd0);
        chk("reset_value", {32'd0, out_value}, 64'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // ramp 0..1023
        walk(1, 32, 0, 0, 0, 1'b0, -1, -1, 0, 0, 1023, 1023);
        // negative gradient, negative origin
        walk(-5, 7, 100, -8, 4, 1'b0, -1, -1, 0, 168, 32, 175);
        // ramp under random back-pressure
        walk(1, 32, 0, 0, 0, 1'b1, -1, -1, 0, 0, 1023, 1023);
        // output-width wrap
        walk(1, 0, 64'h7FFF_FFFF, 0, 0, 1'b0, -1, -1, 0, 64'h7FFF_FFFF, 1, 64'h8000_0000);
        // second start mid-walk is ignored
        walk(3, -2, 11, 16, -32, 1'b0, 100, -1, 0, 123, 100, 129);
        // reset mid-walk, then a fresh full walk
        walk(1, 32, 0, 0, 0, 1'b0, -1, 500, 0, 0, 1, 1);
        walk(1, 32, 0, 0, 0, 1'b0, -1, -1, 0, 0, 1023, 1023);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/plane_span_walker.md
Name: plane_span_walker

Overview:
- Consumer-side counterpart to the plane-equation setup/evaluate block in the PVR pipeline.
- Receives the per-triangle plane coefficients (ddx, ddy, c) and a tile origin.
- Walks every pixel of the tile in raster order and emits value = x*ddx + y*ddy + c per pixel on a valid/ready stream.
- After one start-value multiply, it uses only incremental adds, so the per-pixel multipliers drop out of the rasteriser path.

Parameters:
- TILE_W, 32, pixels per row (power of two, ≥2).
- TILE_H, 32, rows per tile (power of two, ≥2).
- COEF_W, 64, signed width of ddx/ddy/c and of the internal accumulators.
- OUT_W, 32, width of out_value (low bits of the accumulator).

Ports:
- clock  in  1  single clock for the whole block.
- reset_n  in  1  reset, synchronous, active-low.
- start  in  1  pulse; request a tile walk (accepted only when busy=0).
- coef_ddx  in  COEF_W  signed x-gradient; sampled on start accept.
- coef_ddy  in  COEF_W  signed y-gradient; sampled on start accept.
- coef_c  in  COEF_W  signed plane constant; sampled on start accept.
- tile_x  in  12  signed tile origin x; sampled on start accept.
- tile_y  in  12  signed tile origin y; sampled on start accept.
- busy  out  1  high from the cycle after start accept until the last beat is handed off.
- out_valid  out  1  pixel beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_x  out  12  signed pixel x (tile_x + column).
- out_y  out  12  signed pixel y (tile_y + row).
- out_value  out  OUT_W  interpolated value, low OUT_W bits of the accumulator.
- out_last  out  1  high on the final beat of the tile.

Behaviour:
- Reset: reset_n low at a clock edge forces state IDLE. busy, out_valid, out_last, out_x, out_y and out_value all become 0. Latched coefficients are cleared to 0. This applies mid-walk too: the walk is abandoned with no further beats.
- FSM: IDLE -> INIT -> SPAN -> IDLE.
- IDLE:
  - start=1 latches coef_ddx/ddy/c and tile_x/y, then goes to INIT.
  - start in any other state is ignored, with no effect on the current walk.
- INIT (one cycle):
  - row_acc <= tile_x*ddx + tile_y*ddy + c (sign-extended 12xCOEF_W products, modulo 2^COEF_W).
  - pix_acc <= same value; col <= 0; row <= 0. Next state is SPAN.
- SPAN:
  - out_valid=1. out_value = pix_acc[OUT_W-1:0], out_x = tile_x+col, out_y = tile_y+row (12-bit wrap). out_last = (col==TILE_W-1 && row==TILE_H-1).
  - On out_valid && out_ready:
    - col<TILE_W-1: col++, pix_acc += ddx.
    - col==TILE_W-1 and not last: col <= 0, row++, row_acc += ddy, pix_acc <= row_acc + ddy.
    - last: go to IDLE; out_valid, out_last and busy deassert on the next cycle.
  - While out_ready=0, all out_* stay stable (no change of value, coordinate or last).
- Latency: start accepted at edge N -> busy=1 and state INIT after N -> first out_valid after edge N+1. Exactly TILE_W*TILE_H beats per start.
- A new start may be accepted in the cycle IDLE is re-entered (busy=0). Back-to-back tiles therefore have a one-cycle gap plus INIT.
- Arithmetic:
  - All accumulators are signed COEF_W and wrap modulo 2^COEF_W; no saturation.
  - Each out_value must equal (x*ddx + y*ddy + c) mod 2^OUT_W computed directly, with no fixed-point shift applied. The caller owns FRAC_BITS scaling.
- Coordinates: col/row counters are log2(TILE_W)/log2(TILE_H) bits wide. out_x/out_y wrap at 12 bits.

Decomposition:
- Shared package pvr_interp_pkg holds:
  - COEF_W and OUT_W defaults, TILE_W/TILE_H defaults (32).
  - The walker state enum (IDLE, INIT, SPAN).
  - The 12-bit screen-coordinate type, shared with the setup/evaluate block.
- One natural sub-module, plane_start_calc: combinational 12xCOEF_W start-value product sum used in INIT, so it can be pipelined later without touching the FSM.

Test Plan:
- ddx=1, ddy=32, c=0, tile (0,0), out_ready=1 -> 1024 beats with out_value 0..1023 in order; out_last only on beat 1023 (x=31,y=31); busy low one cycle after.
- ddx=-5, ddy=7, c=100, tile (-8,4) -> first beat x=-8,y=4,value=168; beat 32 (x=-8,y=5) value=175; every beat matches the direct formula.
- Same as scenario 1 with random out_ready (~40% duty) -> identical value sequence; outputs held stable on every stalled cycle.
- c=0x7FFFFFFF, ddx=1, ddy=0, tile (0,0) -> beat 0 = 0x7FFFFFFF, beat 1 = 0x80000000 (OUT_W wrap, no saturation).
- start pulsed again at beat 100 with different coefficients -> ignored; walk completes with the original coefficients and 1024 beats.
- reset_n low for one cycle at beat 500 -> next cycle out_valid=0, busy=0, all outputs 0; a subsequent start produces a full fresh 1024-beat walk.
